// File: rtl/assoc_cache.sv
// Set-associative write-back, write-allocate cache with true-LRU ages and a full flush walker.
// One word per line; a single FSM sequences lookups, evictions, fills and flushes.
module assoc_cache #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int SETS        = 64,
    parameter int WAYS        = 4,
    parameter int BYTE_OFFSET = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  flush_req,
    output logic                  resp_valid,
    output logic                  resp_hit,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  flush_done,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_we,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - BYTE_OFFSET;
    localparam int CNT_W = IDX_W + WAY_W;

    typedef enum logic [3:0] {
        IDLE, LOOKUP, WRITEBACK, FILL_REQ, FILL_WAIT,
        INSTALL, RESPOND, FLUSH_SCAN, FLUSH_WB, DONE
    } state_t;

    state_t                state;
    logic                  valid_mem [SETS][WAYS];
    logic                  dirty_mem [SETS][WAYS];
    logic [WAY_W-1:0]      age_mem   [SETS][WAYS];
    logic [TAG_W-1:0]      tag_mem   [SETS][WAYS];
    logic [DATA_WIDTH-1:0] data_mem  [SETS][WAYS];

    logic                  we_r;
    logic [TAG_W-1:0]      tag_r;
    logic [IDX_W-1:0]      idx_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [DATA_WIDTH-1:0] fill_r;
    logic [WAY_W-1:0]      victim_r;
    logic [CNT_W-1:0]      flush_cnt;

    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic                  found_invalid;
    logic [WAY_W-1:0]      victim;
    logic                  touch_en;
    logic [WAY_W-1:0]      touch_way;
    logic [IDX_W-1:0]      fl_idx;
    logic [WAY_W-1:0]      fl_way;

    assign fl_idx = flush_cnt[CNT_W-1:WAY_W];
    assign fl_way = flush_cnt[WAY_W-1:0];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hit           = 1'b0;
        hit_way       = '0;
        found_invalid = 1'b0;
        victim        = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_mem[idx_r][w] && tag_mem[idx_r][w] == tag_r) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        // Lowest invalid way wins; with a full set the oldest (age WAYS-1) is evicted.
        for (int w = 0; w < WAYS; w++) begin
            if (!found_invalid && !valid_mem[idx_r][w]) begin
                found_invalid = 1'b1;
                victim        = WAY_W'(w);
            end
        end
        if (!found_invalid) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_mem[idx_r][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
            end
        end
    end

    assign touch_en  = (state == LOOKUP && hit) || state == INSTALL;
    assign touch_way = (state == INSTALL) ? victim_r : hit_way;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            we_r      <= 1'b0;
            tag_r     <= '0;
            idx_r     <= '0;
            wdata_r   <= '0;
            fill_r    <= '0;
            victim_r  <= '0;
            flush_cnt <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_mem[s][w] <= 1'b0;
                    dirty_mem[s][w] <= 1'b0;
                    age_mem[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            if (touch_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == touch_way)
                        age_mem[idx_r][w] <= '0;
                    else if (age_mem[idx_r][w] < age_mem[idx_r][touch_way])
                        age_mem[idx_r][w] <= age_mem[idx_r][w] + 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (flush_req) begin
                        state <= FLUSH_SCAN;
                    end else if (req_valid) begin
                        we_r    <= req_we;
                        tag_r   <= req_addr[ADDR_WIDTH-1 -: TAG_W];
                        idx_r   <= req_addr[BYTE_OFFSET +: IDX_W];
                        wdata_r <= req_wdata;
                        state   <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    victim_r <= victim;
                    if (hit) begin
                        if (we_r) dirty_mem[idx_r][hit_way] <= 1'b1;
                        state <= IDLE;
                    end else if (valid_mem[idx_r][victim] && dirty_mem[idx_r][victim]) begin
                        state <= WRITEBACK;
                    end else begin
                        state <= we_r ? INSTALL : FILL_REQ;
                    end
                end
                WRITEBACK: begin
                    if (mem_req_ready) begin
                        dirty_mem[idx_r][victim_r] <= 1'b0;
                        state <= we_r ? INSTALL : FILL_REQ;
                    end
                end
                FILL_REQ:  if (mem_req_ready) state <= FILL_WAIT;
                FILL_WAIT: begin
                    if (mem_resp_valid) begin
                        fill_r <= mem_resp_rdata;
                        state  <= INSTALL;
                    end
                end
                INSTALL: begin
                    valid_mem[idx_r][victim_r] <= 1'b1;
                    dirty_mem[idx_r][victim_r] <= we_r;
                    state <= RESPOND;
                end
                RESPOND: state <= IDLE;
                FLUSH_SCAN: begin
                    if (valid_mem[fl_idx][fl_way] && dirty_mem[fl_idx][fl_way]) begin
                        state <= FLUSH_WB;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                        state     <= (&flush_cnt) ? DONE : FLUSH_SCAN;
                    end
                end
                FLUSH_WB: begin
                    if (mem_req_ready) begin
                        dirty_mem[fl_idx][fl_way] <= 1'b0;
                        flush_cnt <= flush_cnt + 1'b1;
                        state     <= (&flush_cnt) ? DONE : FLUSH_SCAN;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: tag and data arrays are not reset; valid bits alone decide whether contents count.
    always_ff @(posedge clk) begin
        if (state == LOOKUP && hit && we_r) data_mem[idx_r][hit_way] <= wdata_r;
        if (state == INSTALL) begin
            data_mem[idx_r][victim_r] <= we_r ? wdata_r : fill_r;
            tag_mem[idx_r][victim_r]  <= tag_r;
        end
    end

    assign req_ready  = rst_n && state == IDLE && !flush_req;
    assign resp_valid = (state == LOOKUP && hit) || state == RESPOND;
    assign resp_hit   = state == LOOKUP && hit;
    assign flush_done = state == DONE;

    always_comb begin
        resp_rdata = '0;
        if (state == LOOKUP && hit) resp_rdata = data_mem[idx_r][hit_way];
        else if (state == RESPOND)  resp_rdata = data_mem[idx_r][victim_r];
    end

    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        case (state)
            WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {tag_mem[idx_r][victim_r], idx_r, {BYTE_OFFSET{1'b0}}};
                mem_req_wdata = data_mem[idx_r][victim_r];
            end
            FILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {tag_r, idx_r, {BYTE_OFFSET{1'b0}}};
            end
            FLUSH_WB: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {tag_mem[fl_idx][fl_way], fl_idx, {BYTE_OFFSET{1'b0}}};
                mem_req_wdata = data_mem[fl_idx][fl_way];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache at default parameters (index=addr[7:2], tag=addr[15:8]).
// A small memory responder inside cpu_op/run_flush logs every memory request.
module tb_assoc_cache;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        flush_req = 1'b0;
    logic        resp_valid, resp_hit, flush_done;
    logic [31:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready = 1'b1, mem_req_we;
    logic [15:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_rdata = '0;

    int total = 0;
    int bad = 0;

    logic        op_got, op_hit;
    logic [31:0] op_rdata;
    int          op_lat;
    int          done_at;
    logic [15:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [15:0] rd_addr[$];

    assoc_cache dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .flush_req(flush_req),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
        .flush_done(flush_done),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = 1'b0; flush_req = 1'b0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_log();
        wr_addr.delete(); wr_data.delete(); rd_addr.delete();
    endtask

    // One CPU transaction; answers a fill with `fill` one cycle after the read handshake.
    task automatic cpu_op(input logic we, input logic [15:0] addr,
                          input logic [31:0] wdata, input logic [31:0] fill);
        logic pend;
        int   wait_c;
        pend = 1'b0; op_got = 1'b0; op_hit = 1'b0; op_rdata = '0; op_lat = 0;
        clear_log();
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        wait_c = 0;
        while (!req_ready && wait_c < 20) begin
            @(negedge clk);
            wait_c++;
        end
        @(posedge clk);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            mem_resp_valid = 1'b0;
            if (pend) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = fill;
                pend = 1'b0;
            end
            if (resp_valid) begin
                op_got = 1'b1; op_hit = resp_hit; op_rdata = resp_rdata; op_lat = c;
                break;
            end
            if (mem_req_valid && mem_req_ready) begin
                if (mem_req_we) begin
                    wr_addr.push_back(mem_req_addr);
                    wr_data.push_back(mem_req_wdata);
                end else begin
                    rd_addr.push_back(mem_req_addr);
                    pend = 1'b1;
                end
            end
        end
        mem_resp_valid = 1'b0;
    endtask

    task automatic run_flush(input logic with_req);
        done_at = 0;
        clear_log();
        @(negedge clk);
        flush_req = 1'b1;
        req_valid = with_req; req_we = 1'b0; req_addr = 16'h0300;
        #1;
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL flush_priority_ready: got=%0b want=0", req_ready); end
        @(posedge clk);
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            flush_req = 1'b0; req_valid = 1'b0;
            if (flush_done) begin
                done_at = c;
                break;
            end
            if (mem_req_valid && mem_req_ready && mem_req_we) begin
                wr_addr.push_back(mem_req_addr);
                wr_data.push_back(mem_req_wdata);
            end
        end
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({req_ready, resp_valid, flush_done, mem_req_valid} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs: got=%b want=0000", {req_ready, resp_valid, flush_done, mem_req_valid});
        end
        total++;
        if ({resp_rdata, mem_req_addr, mem_req_wdata, mem_req_we} !== 81'd0) begin
            bad++; $display("FAIL reset_data_outputs: got nonzero, want zero");
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got=%0b want=1", req_ready); end
    endtask

    task automatic test_read_miss_hit();
        logic [15:0] a;
        apply_reset();
        cpu_op(1'b0, 16'h0100, 32'h0, 32'hDEADBEEF);
        a = (rd_addr.size() > 0) ? rd_addr[0] : 16'hxxxx;
        total++;
        if (rd_addr.size() != 1 || wr_addr.size() != 0 || a !== 16'h0100) begin
            bad++; $display("FAIL rd_miss_mem: reads=%0d writes=%0d addr=%h want 1/0/0100", rd_addr.size(), wr_addr.size(), a);
        end
        total++;
        if (op_got !== 1'b1 || op_hit !== 1'b0 || op_rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rd_miss_resp: got=%0b hit=%0b data=%h want 1/0/deadbeef", op_got, op_hit, op_rdata);
        end
        cpu_op(1'b0, 16'h0100, 32'h0, 32'h0BAD0BAD);
        total++;
        if (op_hit !== 1'b1 || op_rdata !== 32'hDEADBEEF || op_lat != 1) begin
            bad++; $display("FAIL rd_hit: hit=%0b data=%h lat=%0d want 1/deadbeef/1", op_hit, op_rdata, op_lat);
        end
        total++;
        if (rd_addr.size() + wr_addr.size() != 0) begin
            bad++; $display("FAIL rd_hit_no_mem: got=%0d requests want 0", rd_addr.size() + wr_addr.size());
        end
    endtask

    task automatic test_write_miss();
        apply_reset();
        cpu_op(1'b1, 16'h0200, 32'h12345678, 32'h0);
        total++;
        if (op_got !== 1'b1 || op_hit !== 1'b0 || op_rdata !== 32'h12345678 || rd_addr.size() + wr_addr.size() != 0) begin
            bad++; $display("FAIL wr_miss: got=%0b hit=%0b data=%h mem=%0d want 1/0/12345678/0",
                            op_got, op_hit, op_rdata, rd_addr.size() + wr_addr.size());
        end
        cpu_op(1'b0, 16'h0200, 32'h0, 32'h0);
        total++;
        if (op_hit !== 1'b1 || op_rdata !== 32'h12345678) begin
            bad++; $display("FAIL wr_then_rd_hit: hit=%0b data=%h want 1/12345678", op_hit, op_rdata);
        end
    endtask

    task automatic test_dirty_evict();
        logic [15:0] wa, ra;
        logic [31:0] wd;
        apply_reset();
        for (int t = 1; t <= 4; t++) cpu_op(1'b1, 16'(t << 8), 32'hA000_0000 + 32'(t), 32'h0);
        cpu_op(1'b0, 16'h0500, 32'h0, 32'h5555_AAAA);
        wa = (wr_addr.size() > 0) ? wr_addr[0] : 16'hxxxx;
        wd = (wr_data.size() > 0) ? wr_data[0] : 32'hxxxxxxxx;
        ra = (rd_addr.size() > 0) ? rd_addr[0] : 16'hxxxx;
        total++;
        if (wr_addr.size() != 1 || wa !== 16'h0100 || wd !== 32'hA000_0001) begin
            bad++; $display("FAIL evict_writeback: n=%0d addr=%h data=%h want 1/0100/a0000001", wr_addr.size(), wa, wd);
        end
        total++;
        if (rd_addr.size() != 1 || ra !== 16'h0500 || op_hit !== 1'b0 || op_rdata !== 32'h5555_AAAA) begin
            bad++; $display("FAIL evict_fill: n=%0d addr=%h hit=%0b data=%h want 1/0500/0/5555aaaa",
                            rd_addr.size(), ra, op_hit, op_rdata);
        end
    endtask

    task automatic test_lru();
        apply_reset();
        for (int t = 1; t <= 4; t++) cpu_op(1'b0, 16'(t << 8), 32'h0, 32'hC000_0000 + 32'(t));
        cpu_op(1'b0, 16'h0100, 32'h0, 32'h0);
        cpu_op(1'b0, 16'h0500, 32'h0, 32'hC000_0005);
        total++;
        if (wr_addr.size() != 0 || rd_addr.size() != 1 || op_hit !== 1'b0) begin
            bad++; $display("FAIL lru_clean_evict: writes=%0d reads=%0d hit=%0b want 0/1/0", wr_addr.size(), rd_addr.size(), op_hit);
        end
        cpu_op(1'b0, 16'h0100, 32'h0, 32'h0);
        total++;
        if (op_hit !== 1'b1 || op_rdata !== 32'hC000_0001) begin
            bad++; $display("FAIL lru_mru_kept: hit=%0b data=%h want 1/c0000001", op_hit, op_rdata);
        end
        cpu_op(1'b0, 16'h0200, 32'h0, 32'hC000_0002);
        total++;
        if (op_hit !== 1'b0) begin bad++; $display("FAIL lru_victim_gone: hit=%0b want 0", op_hit); end
    endtask

    task automatic test_flush();
        apply_reset();
        cpu_op(1'b1, 16'h0100, 32'h1111_0001, 32'h0);
        cpu_op(1'b1, 16'h0204, 32'h2222_0002, 32'h0);
        run_flush(1'b1);
        total++;
        if (wr_addr.size() != 2 || done_at != 64 * 4 + 2 + 1) begin
            bad++; $display("FAIL flush1: writes=%0d done_at=%0d want 2/259", wr_addr.size(), done_at);
        end
        total++;
        if (wr_addr.size() != 2 || wr_addr[0] !== 16'h0100 || wr_addr[1] !== 16'h0204 ||
            wr_data[0] !== 32'h1111_0001 || wr_data[1] !== 32'h2222_0002) begin
            bad++; $display("FAIL flush1_lines: got wrong write-back addresses or data (n=%0d)", wr_addr.size());
        end
        @(negedge clk);
        total++;
        if (flush_done !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL flush_done_pulse: done=%0b ready=%0b want 0/1", flush_done, req_ready);
        end
        run_flush(1'b0);
        total++;
        if (wr_addr.size() != 0 || done_at != 64 * 4 + 1) begin
            bad++; $display("FAIL flush2: writes=%0d done_at=%0d want 0/257", wr_addr.size(), done_at);
        end
        cpu_op(1'b0, 16'h0100, 32'h0, 32'h0);
        total++;
        if (op_hit !== 1'b1 || op_rdata !== 32'h1111_0001) begin
            bad++; $display("FAIL flush_keeps_valid: hit=%0b data=%h want 1/11110001", op_hit, op_rdata);
        end
    endtask

    task automatic test_reset_in_writeback();
        logic seen;
        apply_reset();
        for (int t = 1; t <= 4; t++) cpu_op(1'b1, 16'(t << 8), 32'hB000_0000 + 32'(t), 32'h0);
        @(negedge clk);
        mem_req_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0500;
        @(posedge clk);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (mem_req_valid) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (seen !== 1'b1 || mem_req_we !== 1'b1 || mem_req_addr !== 16'h0100 || mem_req_wdata !== 32'hB000_0001) begin
            bad++; $display("FAIL wb_request: seen=%0b we=%0b addr=%h data=%h want 1/1/0100/b0000001",
                            seen, mem_req_we, mem_req_addr, mem_req_wdata);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (mem_req_valid !== 1'b0 || req_ready !== 1'b0) begin
            bad++; $display("FAIL async_reset_in_wb: mem_req_valid=%0b ready=%0b want 0/0", mem_req_valid, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mem_req_ready = 1'b1;
        cpu_op(1'b0, 16'h0100, 32'h0, 32'h7777_0000);
        total++;
        if (op_hit !== 1'b0 || rd_addr.size() != 1) begin
            bad++; $display("FAIL post_reset_miss: hit=%0b reads=%0d want 0/1", op_hit, rd_addr.size());
        end
    endtask

    initial begin
        test_reset();
        test_read_miss_hit();
        test_write_miss();
        test_dirty_evict();
        test_lru();
        test_flush();
        test_reset_in_writeback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
